// File: rtl/cache_types_pkg.sv
// Shared cache types: address field widths, the MSHR entry layout and the
// refill-stage state, victim bundle and next-state helper.
package cache_types_pkg;

   localparam int unsigned ADDR_BIT_LEN      = 32;
   localparam int unsigned BYTE_OFF_BIT_LEN  = 2;
   localparam int unsigned BLOCK_OFF_BIT_LEN = 2;
   localparam int unsigned INDEX_BIT_LEN     = 6;
   localparam int unsigned TAG_BIT_LEN       = ADDR_BIT_LEN - INDEX_BIT_LEN
                                               - BLOCK_OFF_BIT_LEN - BYTE_OFF_BIT_LEN;
   localparam int unsigned UUID_BIT_LEN      = 8;
   localparam int unsigned WORDS_PER_BLOCK   = 2 ** BLOCK_OFF_BIT_LEN;
   localparam int unsigned WORD_W            = 32;

   typedef struct packed {
      logic                                   valid;
      logic [UUID_BIT_LEN-1:0]                uuid;
      logic [ADDR_BIT_LEN-1:0]                block_addr;
      logic [WORDS_PER_BLOCK-1:0]             write_status;
      logic [WORDS_PER_BLOCK-1:0][WORD_W-1:0] write_block;
   } mshr_reg;

   typedef enum logic [1:0] {
      IDLE,
      EVICT,
      FETCH,
      FILL
   } refill_state_t;

   typedef struct packed {
      logic                                   valid;
      logic                                   dirty;
      logic [TAG_BIT_LEN-1:0]                 tag;
      logic [WORDS_PER_BLOCK-1:0][WORD_W-1:0] data;
   } victim_info;

   // A miss whose every word is being stored needs no fetch from memory.
   function automatic refill_state_t miss_next_state(input logic [WORDS_PER_BLOCK-1:0] ws);
      return (&ws) ? FILL : FETCH;
   endfunction

endpackage

// File: rtl/cache_miss_refill.sv
// Miss-service stage: writes back a dirty victim, fetches the missing block,
// merges buffered store words and fills the bank line, one miss at a time.
module cache_miss_refill #(
   parameter int unsigned BLOCK_WORDS = 4,
   parameter int unsigned WORD_W      = 32,
   parameter int unsigned ADDR_W      = 32
) (
   input  logic                                      CLK,
   input  logic                                      RST,
   input  cache_types_pkg::mshr_reg                  mshr_in,
   output logic                                      bank_empty,
   input  logic                                      victim_valid,
   input  logic                                      victim_dirty,
   input  logic [cache_types_pkg::TAG_BIT_LEN-1:0]   victim_tag,
   input  logic [BLOCK_WORDS*WORD_W-1:0]             victim_data,
   output logic                                      mem_req_valid,
   output logic                                      mem_req_write,
   output logic [ADDR_W-1:0]                         mem_req_addr,
   output logic [WORD_W-1:0]                         mem_req_wdata,
   input  logic                                      mem_resp_valid,
   input  logic [WORD_W-1:0]                         mem_resp_rdata,
   output logic                                      fill_en,
   output logic [ADDR_W-1:0]                         fill_addr,
   output logic [BLOCK_WORDS*WORD_W-1:0]             fill_data,
   output logic                                      fill_dirty,
   output logic                                      done_valid,
   output logic [cache_types_pkg::UUID_BIT_LEN-1:0]  done_uuid
);
   import cache_types_pkg::*;

   localparam int unsigned CNT_W   = BLOCK_OFF_BIT_LEN;
   localparam int unsigned IDX_LSB = BYTE_OFF_BIT_LEN + BLOCK_OFF_BIT_LEN;
   localparam int unsigned TAG_LSB = IDX_LSB + INDEX_BIT_LEN;

   refill_state_t                           state_q, state_d;
   logic [CNT_W-1:0]                        word_cnt_q, word_cnt_d;
   logic [UUID_BIT_LEN-1:0]                 uuid_q, uuid_d;
   logic [ADDR_W-1:0]                       block_addr_q, block_addr_d;
   logic [BLOCK_WORDS-1:0]                  ws_q, ws_d;
   logic [TAG_BIT_LEN-1:0]                  vtag_q, vtag_d;
   logic [BLOCK_WORDS-1:0][WORD_W-1:0]      vdata_q, vdata_d;
   logic [BLOCK_WORDS-1:0][WORD_W-1:0]      line_q, line_d;
   victim_info                              victim_in;
   logic                                    last_word;

   assign victim_in = '{valid: victim_valid, dirty: victim_dirty,
                        tag: victim_tag, data: victim_data};
   assign last_word = (word_cnt_q == CNT_W'(BLOCK_WORDS - 1));

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= IDLE;
         word_cnt_q   <= '0;
         uuid_q       <= '0;
         block_addr_q <= '0;
         ws_q         <= '0;
         vtag_q       <= '0;
         vdata_q      <= '0;
         line_q       <= '0;
      end else begin
         state_q      <= state_d;
         word_cnt_q   <= word_cnt_d;
         uuid_q       <= uuid_d;
         block_addr_q <= block_addr_d;
         ws_q         <= ws_d;
         vtag_q       <= vtag_d;
         vdata_q      <= vdata_d;
         line_q       <= line_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      word_cnt_d    = word_cnt_q;
      uuid_d        = uuid_q;
      block_addr_d  = block_addr_q;
      ws_d          = ws_q;
      vtag_d        = vtag_q;
      vdata_d       = vdata_q;
      line_d        = line_q;
      bank_empty    = 1'b0;
      mem_req_valid = 1'b0;
      mem_req_write = 1'b0;
      mem_req_addr  = '0;
      mem_req_wdata = '0;
      fill_en       = 1'b0;
      fill_addr     = '0;
      fill_data     = '0;
      fill_dirty    = 1'b0;
      done_valid    = 1'b0;
      done_uuid     = '0;

      unique case (state_q)
         IDLE: begin
            bank_empty = 1'b1;
            if (mshr_in.valid) begin
               uuid_d       = mshr_in.uuid;
               block_addr_d = mshr_in.block_addr;
               ws_d         = mshr_in.write_status;
               vtag_d       = victim_in.tag;
               vdata_d      = victim_in.data;
               // Preloading store data lets FETCH overwrite only unstored words.
               line_d       = mshr_in.write_block;
               word_cnt_d   = '0;
               if (victim_in.valid && victim_in.dirty) state_d = EVICT;
               else                                    state_d = miss_next_state(mshr_in.write_status);
            end
         end
         EVICT: begin
            mem_req_valid = 1'b1;
            mem_req_write = 1'b1;
            mem_req_addr  = {vtag_q, block_addr_q[TAG_LSB-1:IDX_LSB], word_cnt_q,
                             {BYTE_OFF_BIT_LEN{1'b0}}};
            mem_req_wdata = vdata_q[word_cnt_q];
            if (mem_resp_valid) begin
               word_cnt_d = word_cnt_q + 1'b1;
               if (last_word) state_d = miss_next_state(ws_q);
            end
         end
         FETCH: begin
            mem_req_valid = 1'b1;
            mem_req_addr  = {block_addr_q[ADDR_W-1:IDX_LSB], word_cnt_q,
                             {BYTE_OFF_BIT_LEN{1'b0}}};
            if (mem_resp_valid) begin
               if (!ws_q[word_cnt_q]) line_d[word_cnt_q] = mem_resp_rdata;
               word_cnt_d = word_cnt_q + 1'b1;
               if (last_word) state_d = FILL;
            end
         end
         FILL: begin
            fill_en    = 1'b1;
            fill_addr  = block_addr_q;
            fill_data  = line_q;
            fill_dirty = |ws_q;
            done_valid = 1'b1;
            done_uuid  = uuid_q;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: doc/cache_miss_refill.md
Name: cache_miss_refill

Overview:
- Miss-service stage directly downstream of the MSHR buffer.
- Takes the head MSHR entry and, if the victim line is dirty, writes it back to memory word by word.
- Fetches the missing block word by word and merges the buffered store words (write_status/write_block) over the fetched data.
- Writes the merged line into the cache bank and reports completion by uuid. Its bank_empty output is the MSHR buffer's advance/accept signal.

Parameters:
- BLOCK_WORDS, 4, words per cache block (equals 2**BLOCK_OFF_BIT_LEN).
- WORD_W, 32, data word width in bits.
- ADDR_W, 32, byte address width.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- mshr_in  in  mshr_reg  MSHR buffer head entry (valid, uuid, block_addr, write_status, write_block).
- bank_empty  out  1  high only in IDLE; the MSHR buffer shifts and this block captures mshr_in in the same cycle.
- victim_valid  in  1  bank line at mshr_in's index is valid; sampled at capture.
- victim_dirty  in  1  victim line is dirty; sampled at capture.
- victim_tag  in  TAG_BIT_LEN  victim tag; sampled at capture.
- victim_data  in  BLOCK_WORDS*WORD_W  victim line data; sampled at capture.
- mem_req_valid  out  1  memory word request.
- mem_req_write  out  1  1 = write, 0 = read.
- mem_req_addr  out  ADDR_W  word-aligned byte address.
- mem_req_wdata  out  WORD_W  write data.
- mem_resp_valid  in  1  acknowledges the current request; for reads it carries the data.
- mem_resp_rdata  in  WORD_W  read data.
- fill_en  out  1  one-cycle bank line write.
- fill_addr  out  ADDR_W  block address of the line being written.
- fill_data  out  BLOCK_WORDS*WORD_W  merged line.
- fill_dirty  out  1  |write_status of the captured entry.
- done_valid  out  1  one-cycle completion pulse.
- done_uuid  out  UUID width  uuid of the completed miss.

Behaviour:
- States: IDLE, EVICT, FETCH, FILL.
- Reset (RST high at a clock edge): state goes to IDLE and the word counter clears. All outputs are 0 except bank_empty, which is 1. Any in-flight transaction is dropped; there is no writeback or fill. Reset wins over all other events in that cycle.
- IDLE:
  - bank_empty = 1.
  - If mshr_in.valid, latch the entry and the victim_* inputs, clear word_cnt, and then:
    - go to EVICT if victim_valid && victim_dirty;
    - else go to FETCH if write_status is not all ones;
    - else go to FILL (full-write miss; no fetch needed).
  - If mshr_in.valid is low, stay in IDLE.
- EVICT:
  - mem_req_valid = 1, mem_req_write = 1.
  - mem_req_addr = {victim_tag, index, word_cnt, byte offset 0}.
  - mem_req_wdata = victim word[word_cnt].
  - Hold the request until mem_resp_valid, which may assert in the same cycle as the request.
  - On each ack, word_cnt increments. On the ack of the last word (word_cnt == BLOCK_WORDS-1), word_cnt wraps to 0 and the next state is chosen by the same FETCH/FILL rule as IDLE.
- FETCH:
  - Read requests to {block_addr tag/index, word_cnt}, acked one word at a time.
  - On each ack, line[word_cnt] = write_status[word_cnt] ? write_block[word_cnt] : mem_resp_rdata.
  - Words with write_status set are still fetched; their fetched data is discarded.
  - On the last ack, go to FILL.
- FILL:
  - Exactly one cycle: fill_en = 1 and done_valid = 1.
  - fill_addr = latched block_addr; fill_data = merged line (for a full-write miss, write_block directly).
  - fill_dirty = |write_status; done_uuid = latched uuid.
  - Next state is IDLE.
- mem_resp_valid while mem_req_valid = 0 is ignored.
- mem_req_* must stay stable while mem_req_valid = 1 and no ack has arrived.
- Only one miss is in service at a time; MSHR entries wait in the buffer while bank_empty = 0.
- Minimum latency, clean victim and zero-wait memory: capture at cycle 0, FETCH cycles 1..4, FILL at cycle 5, bank_empty high again at cycle 6.

Decomposition:
- cache_types_pkg additions: refill_state_t enum; constants WORDS_PER_BLOCK and WORD_W; a victim_info struct {valid, dirty, tag, data}.
- mshr_reg and the address field widths are reused from the package unchanged.
- No sub-module: the FSM, the word counter and the line merge register fit in one module.

Test Plan:
- Clean-victim read miss, uuid 5, block_addr 0x0000_1040, write_status 0, zero-wait memory returning 0xA0..0xA3 -> four read requests to 0x1040/44/48/4C. FILL at cycle 5 with fill_data {A3,A2,A1,A0}, fill_dirty 0, done_uuid 5.
- Store merge, write_status 4'b0010, write_block[1] = 0xDEAD_BEEF -> four reads are issued. fill_data word1 = 0xDEADBEEF, the other words come from memory, fill_dirty 1.
- Dirty victim with tag 0x7, victim_data {3,2,1,0} -> four writes to the victim tag addresses with wdata 0..3 precede the four reads; done_valid pulses exactly once.
- Full-write miss, write_status 4'b1111 -> no mem_req_valid at all. FILL in the cycle after capture; fill_data = write_block.
- Memory waits of 3 cycles per word, plus a spurious mem_resp_valid while in IDLE -> request fields are stable through each wait, the spurious response is ignored, and bank_empty stays 0 until the cycle after FILL.
- RST asserted mid-FETCH after 2 of 4 acks -> next cycle state is IDLE and bank_empty = 1, with no fill_en and no done_valid. A new miss is then serviced from word 0.
